// File: rtl/key_debounce.sv
// key_debounce: turns raw active-low, bouncing, asynchronous push-buttons into
// clean per-key press/release strobes and a debounced held level.
// Each key has its own synchronizer, FSM, debounce counter and repeat counter.
// The optional auto-repeat re-issues press strobes while a key stays down.
module key_debounce #(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int CNT_W           = 25
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] buttons,
    output logic [N_KEYS-1:0] pressed,
    output logic [N_KEYS-1:0] released,
    output logic [N_KEYS-1:0] held
);

    // Terminal counts: counters are compared for equality, so they never wrap.
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        DOWN       = 2'd2,
        DB_RELEASE = 2'd3
    } state_t;

    logic [N_KEYS-1:0] sync1_q;
    logic [N_KEYS-1:0] sync2_q;
    logic [N_KEYS-1:0] sync1_d;

    // Invert the active-low pins so that 1 means "key down" from here on.
    always_comb begin
        sync1_d = ~buttons;
    end

    // Two-flop synchronizer per key; sync2_q is the raw level used by the FSMs.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync1_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_KEYS; gi++) begin : g_key
            state_t           state_q, state_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic [CNT_W-1:0] rcnt_q, rcnt_d;
            logic             phase_q, phase_d;   // 0: waiting first repeat, 1: periodic
            logic             pressed_q, pressed_d;
            logic             released_q, released_d;
            logic             held_q, held_d;
            logic             raw;

            assign raw = sync2_q[gi];

            // Next-state logic: debounce in both directions, optional repeat while DOWN.
            always_comb begin
                state_d    = state_q;
                cnt_d      = cnt_q;
                rcnt_d     = rcnt_q;
                phase_d    = phase_q;
                pressed_d  = 1'b0;
                released_d = 1'b0;
                held_d     = held_q;
                case (state_q)
                    IDLE: begin
                        if (raw) begin
                            state_d = DB_PRESS;
                            cnt_d   = '0;
                        end
                    end
                    DB_PRESS: begin
                        if (!raw) begin
                            // Bounce rejected silently.
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else if (cnt_q == DB_LAST) begin
                            state_d   = DOWN;
                            pressed_d = 1'b1;
                            held_d    = 1'b1;
                            rcnt_d    = '0;
                            cnt_d     = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    DOWN: begin
                        if (!raw) begin
                            // rcnt is left untouched so a rejected release resumes it.
                            state_d = DB_RELEASE;
                            cnt_d   = '0;
                        end else if (REPEAT_EN != 0) begin
                            if (rcnt_q == (phase_q ? PER_LAST : DLY_LAST)) begin
                                pressed_d = 1'b1;
                                rcnt_d    = '0;
                                phase_d   = 1'b1;
                            end else begin
                                rcnt_d = rcnt_q + 1'b1;
                            end
                        end
                    end
                    DB_RELEASE: begin
                        if (raw) begin
                            // Release glitch: back to DOWN, held never dropped.
                            state_d = DOWN;
                            cnt_d   = '0;
                        end else if (cnt_q == DB_LAST) begin
                            state_d    = IDLE;
                            released_d = 1'b1;
                            held_d     = 1'b0;
                            phase_d    = 1'b0;
                            rcnt_d     = '0;
                            cnt_d      = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end

            // State and registered outputs; reset never produces a release strobe.
            always_ff @(posedge clk) begin
                if (reset) begin
                    state_q    <= IDLE;
                    cnt_q      <= '0;
                    rcnt_q     <= '0;
                    phase_q    <= 1'b0;
                    pressed_q  <= 1'b0;
                    released_q <= 1'b0;
                    held_q     <= 1'b0;
                end else begin
                    state_q    <= state_d;
                    cnt_q      <= cnt_d;
                    rcnt_q     <= rcnt_d;
                    phase_q    <= phase_d;
                    pressed_q  <= pressed_d;
                    released_q <= released_d;
                    held_q     <= held_d;
                end
            end

            assign pressed[gi]  = pressed_q;
            assign released[gi] = released_q;
            assign held[gi]     = held_q;
        end
    endgenerate

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce. Two instances share the button inputs:
// dut0 without auto-repeat, dut1 with auto-repeat. Each table row is one cycle:
// drive buttons, clock, then compare outputs 1 time unit after the edge.
module tb_key_debounce;

    localparam int NK  = 4;
    localparam int DB  = 8;
    localparam int RD  = 40;
    localparam int RP  = 10;
    localparam int LAT = DB + 3;   // edge after which press/release strobes appear

    logic          clk;
    logic          reset;
    logic [NK-1:0] buttons;
    logic [NK-1:0] p0, r0, h0;
    logic [NK-1:0] p1, r1, h1;

    int checks;
    int failures;

    key_debounce #(
        .N_KEYS(NK), .DEBOUNCE_CYCLES(DB), .REPEAT_EN(0),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .CNT_W(8)
    ) dut0 (
        .clk(clk), .reset(reset), .buttons(buttons),
        .pressed(p0), .released(r0), .held(h0)
    );

    key_debounce #(
        .N_KEYS(NK), .DEBOUNCE_CYCLES(DB), .REPEAT_EN(1),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .CNT_W(8)
    ) dut1 (
        .clk(clk), .reset(reset), .buttons(buttons),
        .pressed(p1), .released(r1), .held(h1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NK-1:0] btn;
        logic [NK-1:0] ep0;   // expected pressed, no repeat
        logic [NK-1:0] ep1;   // expected pressed, with repeat
        logic [NK-1:0] er;    // expected released (both)
        logic [NK-1:0] eh;    // expected held (both)
    } vec_t;

    vec_t tbl[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string name, input int k, input logic [NK-1:0] act,
                       input logic [NK-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%b required=%b", name, k, act, exp);
        end
    endtask

    task automatic check_all(input string name, input int k, input logic [NK-1:0] ep0,
                             input logic [NK-1:0] ep1, input logic [NK-1:0] er,
                             input logic [NK-1:0] eh);
        cmp({name, ".pressed0"},  k, p0, ep0);
        cmp({name, ".released0"}, k, r0, er);
        cmp({name, ".held0"},     k, h0, eh);
        cmp({name, ".pressed1"},  k, p1, ep1);
        cmp({name, ".released1"}, k, r1, er);
        cmp({name, ".held1"},     k, h1, eh);
        cmp({name, ".excl0"},     k, p0 & r0, '0);
        $display("%s k=%0d btn=%b p0=%b p1=%b r=%b h=%b", name, k, buttons, p0, p1, r0, h0);
    endtask

    task automatic add(input logic [NK-1:0] btn, input logic [NK-1:0] ep0,
                       input logic [NK-1:0] ep1, input logic [NK-1:0] er,
                       input logic [NK-1:0] eh);
        vec_t v;
        v.btn = btn; v.ep0 = ep0; v.ep1 = ep1; v.er = er; v.eh = eh;
        tbl.push_back(v);
    endtask

    // Press key mask m for n cycles, then release for LAT+4 cycles (no repeat expected).
    task automatic add_press_release(input logic [NK-1:0] m, input int n);
        for (int k = 1; k <= n; k++)
            add(~m, (k == LAT) ? m : '0, (k == LAT) ? m : '0, '0, (k >= LAT) ? m : '0);
        for (int k = 1; k <= LAT + 4; k++)
            add('1, '0, '0, (k == LAT) ? m : '0, (k < LAT) ? m : '0);
    endtask

    task automatic run_tbl(input string name);
        for (int i = 0; i < tbl.size(); i++) begin
            buttons = tbl[i].btn;
            step();
            check_all(name, i + 1, tbl[i].ep0, tbl[i].ep1, tbl[i].er, tbl[i].eh);
        end
        tbl.delete();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        buttons  = '1;

        // Reset state
        for (int k = 1; k <= 3; k++) begin
            step();
            check_all("reset", k, '0, '0, '0, '0);
        end
        reset = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            step();
            check_all("idle", k, '0, '0, '0, '0);
        end

        // 1: key 0 held 30 cycles, single pulse after edge 11, then release
        add_press_release(4'b0001, 30);
        run_tbl("t1_key0");

        // 2: key 1 bounce of 5 cycles is rejected
        for (int k = 1; k <= 5; k++)  add(4'b1101, '0, '0, '0, '0);
        for (int k = 1; k <= 15; k++) add(4'b1111, '0, '0, '0, '0);
        run_tbl("t2_bounce");

        // 3: key 2 release glitch keeps held, then stable release
        for (int k = 1; k <= 20; k++)
            add(4'b1011, (k == LAT) ? 4'b0100 : '0, (k == LAT) ? 4'b0100 : '0, '0,
                (k >= LAT) ? 4'b0100 : '0);
        for (int k = 1; k <= 4; k++)  add(4'b1111, '0, '0, '0, 4'b0100);
        for (int k = 1; k <= 15; k++) add(4'b1011, '0, '0, '0, 4'b0100);
        for (int k = 1; k <= LAT + 4; k++)
            add(4'b1111, '0, '0, (k == LAT) ? 4'b0100 : '0, (k < LAT) ? 4'b0100 : '0);
        run_tbl("t3_glitch");

        // 4: key 3 held 100 cycles after acceptance: repeats at +40, +50, ... +100
        for (int k = 1; k <= LAT + 100; k++) begin
            logic rep;
            rep = (k == LAT) || (k >= LAT + RD && ((k - LAT - RD) % RP) == 0);
            add(4'b0111, (k == LAT) ? 4'b1000 : '0, rep ? 4'b1000 : '0, '0,
                (k >= LAT) ? 4'b1000 : '0);
        end
        for (int k = 1; k <= LAT + 4 + RP; k++)
            add(4'b1111, '0, '0, (k == LAT) ? 4'b1000 : '0, (k < LAT) ? 4'b1000 : '0);
        run_tbl("t4_repeat");

        // 5: keys 0 and 1 pressed on the same edge
        add_press_release(4'b0011, 15);
        run_tbl("t5_simul");

        // 6: reset mid-DB_PRESS, then mid-DOWN with key 0 still held
        buttons = 4'b1110;
        for (int k = 1; k <= 6; k++) begin
            step();
            check_all("t6_predb", k, '0, '0, '0, '0);
        end
        reset = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            step();
            check_all("t6_rst1", k, '0, '0, '0, '0);
        end
        reset = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            step();
            check_all("t6_post1", k, (k == LAT) ? 4'b0001 : '0, (k == LAT) ? 4'b0001 : '0,
                      '0, (k >= LAT) ? 4'b0001 : '0);
        end
        reset = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            step();
            check_all("t6_rst2", k, '0, '0, '0, '0);
        end
        reset = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            step();
            check_all("t6_post2", k, (k == LAT) ? 4'b0001 : '0, (k == LAT) ? 4'b0001 : '0,
                      '0, (k >= LAT) ? 4'b0001 : '0);
        end
        buttons = 4'b1111;
        for (int k = 1; k <= LAT + 4; k++) begin
            step();
            check_all("t6_rel", k, '0, '0, (k == LAT) ? 4'b0001 : '0,
                      (k < LAT) ? 4'b0001 : '0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
